// File: rtl/sr_latch_driver.sv
// Clocked driver for an asynchronous SR latch: fixed-width s/r pulses, synchronized read-back, confirm or timeout.
// Optional build macro SR_SKIP_REDUNDANT_EN: skip the pulse when the latch already holds the requested value.
module sr_latch_driver #(
  parameter int PULSE_W     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 8
) (
  input  logic clock,
  input  logic reset_,
  input  logic start,
  input  logic op,
  input  logic q_in,
  input  logic qN_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic err,
  output logic q_val
);

  // state | meaning
  // IDLE  | waiting for start; busy=0
  // PULSE | driving s (op=1) or r (op=0) for PULSE_W cycles
  // CHECK | s=r=0, waiting for synchronized q/qN to confirm op_r, bounded by TIMEOUT
  // DONE  | one cycle before done pulses and busy drops
  typedef enum logic [1:0] {IDLE, PULSE, CHECK, DONE} state_t;

  localparam int CNT_MAX = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                 state;
  logic                   op_r;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] q_sync_r;
  logic [SYNC_STAGES-1:0] qn_sync_r;
  logic                   q_sync;
  logic                   qn_sync;
  logic                   consistent;

  assign q_sync     = q_sync_r[SYNC_STAGES-1];
  assign qn_sync    = qn_sync_r[SYNC_STAGES-1];
  assign consistent = (q_sync != qn_sync);

  always_ff @(posedge clock) begin
    if (!reset_) begin
      q_sync_r  <= '0;
      qn_sync_r <= '1;
    end else begin
      q_sync_r  <= {q_sync_r[SYNC_STAGES-2:0], q_in};
      qn_sync_r <= {qn_sync_r[SYNC_STAGES-2:0], qN_in};
    end
  end

  // s and r are only ever raised from IDLE where both are already low, so they can never overlap.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state <= IDLE;
      op_r  <= 1'b0;
      cnt   <= '0;
      s     <= 1'b0;
      r     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      q_val <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= op;
            err  <= 1'b0;
            busy <= 1'b1;
`ifdef SR_SKIP_REDUNDANT_EN
            if (consistent && (q_sync == op)) begin
              q_val <= op;
              state <= DONE;
            end else begin
              s     <= op;
              r     <= ~op;
              cnt   <= CNT_W'(PULSE_W - 1);
              state <= PULSE;
            end
`else
            s     <= op;
            r     <= ~op;
            cnt   <= CNT_W'(PULSE_W - 1);
            state <= PULSE;
`endif
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            s     <= 1'b0;
            r     <= 1'b0;
            cnt   <= CNT_W'(TIMEOUT - 1);
            state <= CHECK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CHECK: begin
          if (consistent && (q_sync == op_r)) begin
            q_val <= op_r;
            state <= DONE;
          end else if (cnt == '0) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: NOR latch model, directed scenarios and random commands vs a transaction-level model.
module tb_sr_latch_driver;
  localparam int PULSE_W     = 3;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 8;
  localparam int MAX_LAT     = 1 + PULSE_W + TIMEOUT + 1 + 4;

  logic clock = 1'b0;
  logic reset_, start, op, q_in, qN_in;
  logic s, r, busy, done, err, q_val;
  logic q_l = 1'b0;
  logic qn_l = 1'b1;
  logic stuck = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  // Transaction-level model of what the latch holds and what the controller reports.
  logic ref_latch = 1'b0;
  logic ref_qval = 1'b0;
  logic ref_err = 1'b0;

  always #5 clock = ~clock;

  always begin
    @(r or qn_l);
    #1 q_l = ~(r | qn_l);
  end
  always begin
    @(s or q_l);
    #1 qn_l = ~(s | q_l);
  end
  assign q_in  = stuck ? 1'b0 : q_l;
  assign qN_in = stuck ? 1'b0 : qn_l;

  sr_latch_driver #(.PULSE_W(PULSE_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_(reset_), .start(start), .op(op), .q_in(q_in), .qN_in(qN_in),
    .s(s), .r(r), .busy(busy), .done(done), .err(err), .q_val(q_val)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic run_cmd(input logic o, input bit noise);
    int k, exp_lat, done_cyc, s_cnt, r_cnt, both, extra;
    bit skip, success;
    skip = 0;
`ifdef SR_SKIP_REDUNDANT_EN
    skip = !stuck && (ref_latch == o);
`endif
    if (stuck) k = TIMEOUT;
    else if (ref_latch == o) k = 1;
    else k = (SYNC_STAGES + 1 - PULSE_W > 1) ? SYNC_STAGES + 1 - PULSE_W : 1;
    exp_lat = skip ? 2 : 1 + PULSE_W + k + 1;
    success = skip || !stuck;
    done_cyc = 0; s_cnt = 0; r_cnt = 0; both = 0;
    start = 1'b1;
    op = o;
    for (int c = 1; c <= MAX_LAT && done_cyc == 0; c++) begin
      @(negedge clock);
      s_cnt += int'(s);
      r_cnt += int'(r);
      both  += int'(s & r);
      if (c == 1) begin
        chk("busy_c1", int'(busy), 1);
        chk("err_cleared_c1", int'(err), 0);
      end
      if (done) begin
        done_cyc = c;
        chk("err_at_done", int'(err), success ? 0 : 1);
        chk("qval_at_done", int'(q_val), success ? int'(o) : int'(ref_qval));
        chk("busy_at_done", int'(busy), 0);
      end
      start = (noise && c < exp_lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      op = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    chk("done_latency", done_cyc, exp_lat);
    chk("s_pulse_cycles", s_cnt, (!skip && o) ? PULSE_W : 0);
    chk("r_pulse_cycles", r_cnt, (!skip && !o) ? PULSE_W : 0);
    chk("s_and_r", both, 0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      extra += int'(done) + int'(s) + int'(r) + int'(busy);
    end
    chk("quiet_after_done", extra, 0);
    if (!skip) ref_latch = o;
    if (success) ref_qval = o;
    ref_err = !success;
    chk("qval_hold_idle", int'(q_val), int'(ref_qval));
    chk("err_sticky", int'(err), int'(ref_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic o;
    reset_ = 1'b0;
    start  = 1'b1;
    op     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("reset_outputs", int'({s, r, busy, done, err, q_val}), 0);
    end
    start  = 1'b0;
    reset_ = 1'b1;
    @(negedge clock);
    chk("no_cmd_after_reset", int'(busy | s | r), 0);
    idle(3);

    run_cmd(1'b1, 1'b0);
    idle(4);
    run_cmd(1'b0, 1'b0);

    idle(2);
    stuck = 1'b1;
    idle(4);
    run_cmd(1'b1, 1'b0);
    stuck = 1'b0;
    idle(4);
    run_cmd(1'b1, 1'b0);

    idle(4);
    o = ~ref_latch;
    start = 1'b1;
    op = o;
    @(negedge clock);
    start = 1'b0;
    chk("abort_line_c1", int'({s, r}), o ? 2 : 1);
    @(negedge clock);
    reset_ = 1'b0;
    @(negedge clock);
    chk("abort_drop", int'({s, r, busy, done}), 0);
    reset_ = 1'b1;
    begin
      int dn = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clock);
        dn += int'(done) + int'(busy);
      end
      chk("abort_no_done", dn, 0);
    end
    ref_latch = o;
    ref_qval  = 1'b0;
    ref_err   = 1'b0;
    chk("abort_qval_reset", int'(q_val), 0);

    for (int n = 0; n < 20; n++) begin
      stuck = ($urandom_range(0, 4) == 0);
      idle(4);
      run_cmd(1'($urandom_range(0, 1)), 1'b1);
      stuck = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
